// File: rtl/ir_scan_sequencer.sv
// IR reflectance scan sequencer: emitter settle, sensor charge, then per-channel
// time-to-discharge capture on eight channels with double-buffered results.
module ir_scan_sequencer #(
    parameter int unsigned CHARGE_CYC  = 160,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 48000
) (
    input  logic         WF_CLK,
    input  logic         rst_n,
    input  logic         start,
    input  logic         continuous,
    input  logic [7:0]   ch_en,
    input  logic [7:0]   snsr_in,
    output logic [7:0]   snsr_oe,
    output logic [7:0]   snsr_out,
    output logic         led_even,
    output logic         led_odd,
    output logic [135:0] ttd,
    output logic [7:0]   timed_out,
    output logic         valid,
    output logic         busy
);
    localparam logic [16:0] LP_SETTLE_LAST = 17'(SETTLE_CYC - 1);
    localparam logic [16:0] LP_CHARGE_LAST = 17'(CHARGE_CYC - 1);
    localparam logic [16:0] LP_MEAS_LAST   = 17'(TIMEOUT_CYC - 1);
    localparam logic [16:0] LP_TIMEOUT     = 17'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHARGE,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_en_q;
    logic [7:0]  r_cap;
    logic [16:0] r_cnt;
    logic [16:0] r_work [8];

    logic [7:0]   w_hit;
    logic [7:0]   w_cap_next;
    logic [16:0]  w_work_next [8];
    logic [135:0] w_ttd_final;
    logic [7:0]   w_to_final;
    logic         w_meas_exit;

    always_ff @(posedge WF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= snsr_in;
            r_sync2 <= r_sync1;
        end
    end

    // Final results include captures landing in the last MEASURE cycle.
    always_comb begin
        w_hit       = r_en_q & ~r_cap & ~r_sync2;
        w_cap_next  = r_cap | w_hit;
        w_ttd_final = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            w_work_next[k] = w_hit[k] ? r_cnt : r_work[k];
            if (w_cap_next[k]) begin
                w_ttd_final[17*k +: 17] = w_work_next[k];
            end else if (r_en_q[k]) begin
                w_ttd_final[17*k +: 17] = LP_TIMEOUT;
            end
        end
        w_to_final  = r_en_q & ~w_cap_next;
        w_meas_exit = (w_cap_next == r_en_q) || (r_cnt == LP_MEAS_LAST);
    end

    always_ff @(posedge WF_CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_en_q    <= '0;
            r_cap     <= '0;
            r_cnt     <= '0;
            for (int unsigned k = 0; k < 8; k++) begin
                r_work[k] <= '0;
            end
            snsr_oe   <= '0;
            snsr_out  <= '0;
            led_even  <= 1'b0;
            led_odd   <= 1'b0;
            ttd       <= '0;
            timed_out <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start || continuous) begin
                        r_en_q   <= ch_en;
                        r_cap    <= '0;
                        r_cnt    <= '0;
                        for (int unsigned k = 0; k < 8; k++) begin
                            r_work[k] <= '0;
                        end
                        led_even <= 1'b1;
                        led_odd  <= 1'b1;
                        busy     <= 1'b1;
                        r_state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == LP_SETTLE_LAST) begin
                        r_cnt    <= '0;
                        snsr_oe  <= r_en_q;
                        snsr_out <= '1;
                        r_state  <= ST_CHARGE;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                ST_CHARGE: begin
                    if (r_cnt == LP_CHARGE_LAST) begin
                        r_cnt    <= '0;
                        snsr_oe  <= '0;
                        snsr_out <= '0;
                        r_state  <= ST_MEASURE;
                    end else begin
                        r_cnt <= r_cnt + 17'd1;
                    end
                end
                ST_MEASURE: begin
                    r_cap <= w_cap_next;
                    for (int unsigned k = 0; k < 8; k++) begin
                        r_work[k] <= w_work_next[k];
                    end
                    r_cnt <= r_cnt + 17'd1;
                    if (w_meas_exit) begin
                        ttd       <= w_ttd_final;
                        timed_out <= w_to_final;
                        valid     <= 1'b1;
                        led_even  <= 1'b0;
                        led_odd   <= 1'b0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ir_scan_sequencer.md
IR_SCAN_SEQUENCER -- requirements
Module: ir_scan_sequencer

Interface
REQ-001 Parameter CHARGE_CYC, default 160, meaning sensor capacitor charge time in WF_CLK cycles (10 us at 16 MHz).
REQ-002 Parameter SETTLE_CYC, default 16, meaning emitter-LED on-time before the charge phase begins.
REQ-003 Parameter TIMEOUT_CYC, default 48000, meaning maximum measure window; legal range 2..131071.
REQ-004 WF_CLK  input  1  single system clock; all logic on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 start  input  1  single-scan request, sampled in IDLE only.
REQ-007 continuous  input  1  when 1, a new scan begins automatically after each completed scan.
REQ-008 ch_en  input  8  per-channel enable; sampled and frozen when a scan begins.
REQ-009 snsr_in  input  8  raw sensor pin levels, asynchronous to WF_CLK.
REQ-010 snsr_oe  output  8  per-channel pin drive enable for the top-level tristate.
REQ-011 snsr_out  output  8  per-channel driven pin level.
REQ-012 led_even, led_odd  output  1 each  emitter enables for even and odd channel LEDs.
REQ-013 ttd  output  136  eight 17-bit time-to-discharge results, channel k at bits [17k+16:17k].
REQ-014 timed_out  output  8  per-channel flag: channel did not discharge within TIMEOUT_CYC.
REQ-015 valid  output  1  one-cycle pulse when ttd and timed_out update.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 snsr_in SHALL pass through a 2-flop synchronizer before use; the resulting 2-cycle offset is included in every ttd value.
REQ-018 States SHALL be IDLE, SETTLE, CHARGE, MEASURE, DONE.
REQ-019 IDLE: on start=1 or continuous=1, latch ch_en into en_q and enter SETTLE the next cycle; otherwise remain.
REQ-020 If en_q==0 at latch, the FSM SHALL still complete a full scan, reporting all ttd=0 and timed_out=0.
REQ-021 SETTLE: led_even=led_odd=1, snsr_oe=0; after exactly SETTLE_CYC cycles enter CHARGE.
REQ-022 CHARGE: LEDs on, snsr_oe=en_q, snsr_out=8'hFF; after exactly CHARGE_CYC cycles enter MEASURE.
REQ-023 MEASURE: LEDs on, snsr_oe=0, 17-bit counter starts at 0 in the first MEASURE cycle and increments by 1 each cycle.
REQ-024 MEASURE: for each en_q channel not yet captured, the first cycle its synchronized input reads 0 SHALL capture the counter value into a working register and mark the channel captured.
REQ-025 Captured values SHALL NOT change after first capture (glitches back to 1 ignored).
REQ-026 MEASURE SHALL exit to DONE on the cycle after all en_q channels are captured, or when counter reaches TIMEOUT_CYC-1, whichever is first.
REQ-027 On timeout, each uncaptured enabled channel SHALL report ttd=TIMEOUT_CYC and timed_out=1.
REQ-028 Disabled channels SHALL report ttd=0, timed_out=0, and SHALL never be driven.
REQ-029 DONE: lasts one cycle; ttd and timed_out SHALL update together from the working registers, valid=1, LEDs off, snsr_oe=0.
REQ-030 ttd/timed_out SHALL hold their values between valid pulses (double-buffered; never show partial scans).
REQ-031 After DONE the FSM SHALL return to IDLE; with continuous=1 it restarts SETTLE one cycle later (one IDLE cycle, ch_en re-latched).
REQ-032 start asserted while busy=1 SHALL be ignored and not queued.
REQ-033 Deasserting continuous mid-scan SHALL let the current scan finish normally and then stay in IDLE.
REQ-034 A channel that reads 0 in the first MEASURE cycle SHALL report ttd=0.

Reset
REQ-035 rst_n=0 SHALL immediately force IDLE, snsr_oe=0, snsr_out=0, LEDs off, ttd=0, timed_out=0, valid=0, busy=0, counters and synchronizers cleared.
REQ-036 Reset mid-scan SHALL abort the scan with no valid pulse; first scan after release requires a new start or continuous.

Verification
REQ-037 start=1 one cycle, ch_en=FF, model channel k discharging 100+10k cycles after release -> SETTLE 16, CHARGE 160 cycles, ttd[k]=102+10k, valid once, timed_out=00.
REQ-038 ch_en=0x0F, channels 4..7 held low -> snsr_oe[7:4]=0 throughout, ttd[7:4]=0, scan ends after last of channels 0..3 captured.
REQ-039 TIMEOUT_CYC=1000, channel 3 held high -> ttd[3]=1000, timed_out=0x08, DONE exactly 1000 MEASURE cycles after entry.
REQ-040 continuous=1 for three scans, start pulsed during MEASURE -> exactly three valid pulses, each followed by one IDLE cycle, extra start ignored.
REQ-041 rst_n low during MEASURE -> outputs reach reset values without a clock edge, no valid, ttd retains 0.
REQ-042 channel 2 input glitches 1->0->1->0 during MEASURE -> ttd[2] equals first-low capture value.
